// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_if
// Description : Writeback request / common data bus bundle between execution
//               units (master side) and the CDB arbiter (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int PREG_W  = 7,
    parameter int ROB_W   = 4,
    parameter int DATA_W  = 32
);
    localparam int SRC_W = $clog2(NUM_REQ);

    // Per-unit request side, slice i belongs to unit i
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*PREG_W-1:0] req_prd;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*ROB_W-1:0]  req_rob_tag;

    // Recovery / ROB context
    logic                      flush;
    logic [ROB_W-1:0]          flush_rob_tag;
    logic [ROB_W-1:0]          rob_head;

    // Registered broadcast
    logic                      cdb_valid;
    logic [PREG_W-1:0]         cdb_prd;
    logic [DATA_W-1:0]         cdb_data;
    logic [ROB_W-1:0]          cdb_rob_tag;
    logic [SRC_W-1:0]          cdb_src;

    // Execution units and ROB context drive requests, observe grants and CDB
    modport master (
        output req_valid, req_prd, req_data, req_rob_tag,
        output flush, flush_rob_tag, rob_head,
        input  req_ready,
        input  cdb_valid, cdb_prd, cdb_data, cdb_rob_tag, cdb_src
    );

    // Arbiter consumes requests, produces grants and the broadcast
    modport slave (
        input  req_valid, req_prd, req_data, req_rob_tag,
        input  flush, flush_rob_tag, rob_head,
        output req_ready,
        output cdb_valid, cdb_prd, cdb_data, cdb_rob_tag, cdb_src
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Arbitrates NUM_REQ execution-unit writebacks onto a single
//               registered common data bus. Round-robin grant by default;
//               defining CDB_AGE_PRIORITY_EN selects oldest-first grant.
//               Requests younger than a flushing branch (ROB age relative to
//               rob_head) are squashed and never granted.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PREG_W  = 7,
    parameter int ROB_W   = 4,
    parameter int DATA_W  = 32
) (
    input  wire          clk,
    input  wire          reset,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam logic [SRC_W-1:0] c_last_src = SRC_W'(NUM_REQ - 1);

    // Unpacked per-unit views of the flat request buses
    logic [PREG_W-1:0] w_prd  [NUM_REQ];
    logic [DATA_W-1:0] w_data [NUM_REQ];
    logic [ROB_W-1:0]  w_tag  [NUM_REQ];
    logic [ROB_W-1:0]  w_age  [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic [ROB_W-1:0]  w_flush_age;

    // Arbitration result
    logic              w_found;
    logic [SRC_W-1:0]  w_win;
    logic [NUM_REQ-1:0] w_ready;

    // Output stage
    logic              r_cdb_valid;
    logic [PREG_W-1:0] r_cdb_prd;
    logic [DATA_W-1:0] r_cdb_data;
    logic [ROB_W-1:0]  r_cdb_rob_tag;
    logic [SRC_W-1:0]  r_cdb_src;

    // Age is distance from the ROB head; modular subtraction handles wrap
    assign w_flush_age = bus.flush_rob_tag - bus.rob_head;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_prd[gi]  = bus.req_prd[gi*PREG_W +: PREG_W];
        assign w_data[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        assign w_tag[gi]  = bus.req_rob_tag[gi*ROB_W +: ROB_W];
        assign w_age[gi]  = w_tag[gi] - bus.rob_head;
        // Equal age is the branch itself and survives the flush
        assign w_elig[gi] = bus.req_valid[gi] & ~(bus.flush & (w_age[gi] > w_flush_age));
    end

`ifdef CDB_AGE_PRIORITY_EN
    logic [ROB_W-1:0] w_best_age;

    // Oldest-first: pick the eligible request with the smallest ROB age
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_best_age = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_elig[i] && (!w_found || (w_age[i] < w_best_age))) begin
                w_found    = 1'b1;
                w_win      = SRC_W'(i);
                w_best_age = w_age[i];
            end
        end
    end
`else
    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W:0]   w_sum;
    logic [SRC_W-1:0] w_idx;

    // Round-robin: scan eligible requests from r_rr_ptr upward with wrap
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_sum >= (SRC_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (SRC_W+1)'(NUM_REQ);
            end
            w_idx = w_sum[SRC_W-1:0];
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Pointer moves just past the winner; it holds when nothing is granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_win == c_last_src) ? '0 : w_win + SRC_W'(1);
        end
    end
`endif

    // One-hot grant; suppressed while reset is asserted
    always_comb begin
        w_ready = '0;
        if (w_found && !reset) begin
            w_ready[w_win] = 1'b1;
        end
    end

    // Single-cycle output register; payload holds when nothing is granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cdb_valid   <= 1'b0;
            r_cdb_prd     <= '0;
            r_cdb_data    <= '0;
            r_cdb_rob_tag <= '0;
            r_cdb_src     <= '0;
        end else begin
            r_cdb_valid <= w_found;
            if (w_found) begin
                r_cdb_prd     <= w_prd[w_win];
                r_cdb_data    <= w_data[w_win];
                r_cdb_rob_tag <= w_tag[w_win];
                r_cdb_src     <= w_win;
            end
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.cdb_valid   = r_cdb_valid;
    assign bus.cdb_prd     = r_cdb_prd;
    assign bus.cdb_data    = r_cdb_data;
    assign bus.cdb_rob_tag = r_cdb_rob_tag;
    assign bus.cdb_src     = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Self-checking bench for cdb_arbiter (3 units, 4-bit ROB tag).
//               Directed hand sequences plus a table of per-cycle vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int PREG_W  = 7;
    localparam int ROB_W   = 4;
    localparam int DATA_W  = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .PREG_W(PREG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .PREG_W(PREG_W), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] valid;
        logic [3:0] t0, t1, t2;
        logic       flush;
        logic [3:0] ftag;
        logic [3:0] head;
        logic [2:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_src;
        logic [3:0] exp_tag;
    } vec_t;

    // Fixed per-unit payloads for the table phase
    logic [6:0]  c_prd  [3] = '{7'd10, 7'd11, 7'd12};
    logic [31:0] c_data [3] = '{32'hA000_0000, 32'hB111_1111, 32'hC222_2222};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [3:0] t0, t1, t2,
                         input logic fl, input logic [3:0] ftag, head);
        bus.req_valid     = v;
        bus.req_rob_tag   = {t2, t1, t0};
        bus.req_prd       = {c_prd[2], c_prd[1], c_prd[0]};
        bus.req_data      = {c_data[2], c_data[1], c_data[0]};
        bus.flush         = fl;
        bus.flush_rob_tag = ftag;
        bus.rob_head      = head;
    endtask

    // Watchdog: the bench must never hang
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs [16];
        logic [3:0] last_tag;
        checks = 0;
        errors = 0;

        // ---------------- reset state, requests present during reset -------
        reset = 1'b1;
        drive(3'b001, 4'd3, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        #12;
        chk("reset_ready", bus.req_ready, 3'b000);
        chk("reset_valid", bus.cdb_valid, 1'b0);
        chk("reset_prd",   bus.cdb_prd, 7'd0);
        chk("reset_data",  bus.cdb_data, 32'd0);
        chk("reset_tag",   bus.cdb_rob_tag, 4'd0);
        chk("reset_src",   bus.cdb_src, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);

        // ---------------- single request ------------------------------------
        @(negedge clk);
        drive(3'b001, 4'd3, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        bus.req_prd[6:0]   = 7'd5;
        bus.req_data[31:0] = 32'hDEADBEEF;
        #1;
        chk("single_ready", bus.req_ready, 3'b001);
        @(posedge clk); #1;
        chk("single_valid", bus.cdb_valid, 1'b1);
        chk("single_prd",   bus.cdb_prd, 7'd5);
        chk("single_data",  bus.cdb_data, 32'hDEADBEEF);
        chk("single_tag",   bus.cdb_rob_tag, 4'd3);
        chk("single_src",   bus.cdb_src, 2'd0);

        // ---------------- async reset while broadcasting --------------------
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", bus.cdb_valid, 1'b0);
        chk("midrst_tag",   bus.cdb_rob_tag, 4'd0);
        chk("midrst_ready", bus.req_ready, 3'b000);
        @(negedge clk);
        reset = 1'b0;
        drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);

`ifndef CDB_AGE_PRIORITY_EN
        // ---------------- round-robin / flush / wrap table ------------------
        //          valid   t0 t1 t2  fl  ftag head  ready  v  src tag
        vecs[0]  = '{3'b111, 0, 1, 2, 0, 0, 0,  3'b001, 1, 0, 0};
        vecs[1]  = '{3'b111, 0, 1, 2, 0, 0, 0,  3'b010, 1, 1, 1};
        vecs[2]  = '{3'b111, 0, 1, 2, 0, 0, 0,  3'b100, 1, 2, 2};
        vecs[3]  = '{3'b111, 0, 1, 2, 0, 0, 0,  3'b001, 1, 0, 0};
        vecs[4]  = '{3'b111, 0, 1, 2, 0, 0, 0,  3'b010, 1, 1, 1};
        vecs[5]  = '{3'b111, 0, 1, 2, 0, 0, 0,  3'b100, 1, 2, 2};
        // flush: tag 6 younger than 4, tag 2 older
        vecs[6]  = '{3'b011, 6, 2, 0, 1, 4, 0,  3'b010, 1, 1, 2};
        vecs[7]  = '{3'b001, 6, 0, 0, 1, 4, 0,  3'b000, 0, 0, 0};
        // pointer must still be 2 after the empty flush cycle
        vecs[8]  = '{3'b111, 6, 2, 5, 0, 4, 0,  3'b100, 1, 2, 5};
        // wrap: head 14, flush tag 15
        vecs[9]  = '{3'b001, 1, 0, 0, 1, 15, 14, 3'b000, 0, 0, 0};
        vecs[10] = '{3'b010, 0, 14, 0, 1, 15, 14, 3'b010, 1, 1, 14};
        vecs[11] = '{3'b100, 0, 0, 15, 1, 15, 14, 3'b100, 1, 2, 15};
        vecs[12] = '{3'b001, 1, 0, 0, 0, 15, 14, 3'b001, 1, 0, 1};
        vecs[13] = '{3'b000, 0, 0, 0, 0, 0, 0,  3'b000, 0, 0, 0};
        // pointer held at 1 across the idle cycle -> unit 2 beats unit 0
        vecs[14] = '{3'b101, 0, 1, 2, 0, 0, 0,  3'b100, 1, 2, 2};
        // only the branch itself (tag == flush tag) survives
        vecs[15] = '{3'b111, 0, 5, 9, 1, 0, 0,  3'b001, 1, 0, 0};

        last_tag = 4'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].t0, vecs[i].t1, vecs[i].t2,
                  vecs[i].flush, vecs[i].ftag, vecs[i].head);
            #1;
            chk($sformatf("v%0d_ready", i), bus.req_ready, vecs[i].exp_ready);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), bus.cdb_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                last_tag = vecs[i].exp_tag;
                chk($sformatf("v%0d_src", i),  bus.cdb_src, vecs[i].exp_src);
                chk($sformatf("v%0d_prd", i),  bus.cdb_prd, c_prd[vecs[i].exp_src]);
                chk($sformatf("v%0d_data", i), bus.cdb_data, c_data[vecs[i].exp_src]);
            end
            // payload holds its last value when nothing is broadcast
            chk($sformatf("v%0d_tag", i), bus.cdb_rob_tag, last_tag);
        end
`else
        // ---------------- oldest-first: tags 7,2,5 -> units 1,2,0 -------------
        begin
            logic [2:0] av [3] = '{3'b111, 3'b101, 3'b001};
            logic [1:0] as [3] = '{2'd1, 2'd2, 2'd0};
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                drive(av[i], 4'd7, 4'd2, 4'd5, 1'b0, 4'd0, 4'd0);
                @(posedge clk); #1;
                chk($sformatf("age%0d_valid", i), bus.cdb_valid, 1'b1);
                chk($sformatf("age%0d_src", i),   bus.cdb_src, as[i]);
            end
        end
`endif

        @(negedge clk);
        drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0);
        @(posedge clk); #1;
        chk("final_idle_valid", bus.cdb_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
